hex_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller that shares one 4-bit -> 7-segment hex decoder across NUM_DIGITS digits.

---
 rtl/hex_scan_ctrl.sv | 121 ++++++++++++
 tb/tb_hex_scan_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed hex display scanner: one shared 4-bit -> 7-segment decoder serves
// NUM_DIGITS digits, with a blanking gap at the start of every slot to suppress ghosting.
module hex_scan_ctrl #(
    parameter int ADDR_W   = 2,
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [3:0]               wr_data,
    input  logic                     wr_blank,
    output logic [3:0]               dec_nibble,
    input  logic [6:0]               dec_seg,
    output logic [6:0]               seg,
    output logic [(1<<ADDR_W)-1:0]   dig_sel,
    output logic                     frame_done
);

    localparam int NUM_DIGITS = 1 << ADDR_W;
    localparam int CNT_W      = $clog2(PRESCALE);

    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'(BLANK - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST  = '1;
    localparam logic [6:0]        SEG_OFF   = 7'h7F;

    typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_W-1:0]       idx, idx_nxt;
    logic [CNT_W-1:0]        slot_cnt, cnt_nxt;
    logic [6:0]              seg_nxt;
    logic [NUM_DIGITS-1:0]   sel_nxt;
    logic                    fd_nxt;

    logic [3:0]              nibble_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   blank_q;

    assign dec_nibble = nibble_q[idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                nibble_q[i] <= 4'h0;
            end
            blank_q <= '1;
        end else if (wr_en) begin
            nibble_q[wr_addr] <= wr_data;
            blank_q[wr_addr]  <= wr_blank;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            slot_cnt   <= '0;
            seg        <= SEG_OFF;
            dig_sel    <= '1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            slot_cnt   <= cnt_nxt;
            seg        <= seg_nxt;
            dig_sel    <= sel_nxt;
            frame_done <= fd_nxt;
        end
    end

    // Segments and digit select are computed from the same idx in the same cycle,
    // so a digit's pattern can never be registered alongside another digit's select.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = slot_cnt;
        seg_nxt   = SEG_OFF;
        sel_nxt   = '1;
        fd_nxt    = 1'b0;
        if (!enable) begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_BLANK;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end
                ST_BLANK: begin
                    cnt_nxt = slot_cnt + CNT_W'(1);
                    if (slot_cnt == BLANK_END) begin
                        state_nxt = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    sel_nxt = ~(NUM_DIGITS'(1) << idx);
                    seg_nxt = blank_q[idx] ? SEG_OFF : dec_seg;
                    if (slot_cnt == LAST_CNT) begin
                        cnt_nxt   = '0;
                        idx_nxt   = idx + ADDR_W'(1);
                        state_nxt = ST_BLANK;
                        fd_nxt    = (idx == IDX_LAST);
                    end else begin
                        cnt_nxt = slot_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Directed bench for hex_scan_ctrl with ADDR_W=2, PRESCALE=8, BLANK=2 and a
// behavioural active-low hex decoder on dec_seg.
module tb_hex_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_blank;
    logic [3:0] dec_nibble;
    logic [6:0] dec_seg;
    logic [6:0] seg;
    logic [3:0] dig_sel;
    logic       frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    // Active-low segment codes, bit0 = a ... bit6 = g
    localparam logic [6:0] C_1 = 7'b1111001;
    localparam logic [6:0] C_2 = 7'h24;
    localparam logic [6:0] C_3 = 7'h30;
    localparam logic [6:0] C_4 = 7'h19;
    localparam logic [6:0] C_5 = 7'h12;
    localparam logic [6:0] C_A = 7'h08;
    localparam logic [6:0] OFF = 7'h7F;

    hex_scan_ctrl #(.ADDR_W(2), .PRESCALE(8), .BLANK(2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_blank(wr_blank),
        .dec_nibble(dec_nibble), .dec_seg(dec_seg), .seg(seg),
        .dig_sel(dig_sel), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_model(input logic [3:0] n);
        case (n)
            4'h0: seg_model = 7'h40;  4'h1: seg_model = 7'h79;
            4'h2: seg_model = 7'h24;  4'h3: seg_model = 7'h30;
            4'h4: seg_model = 7'h19;  4'h5: seg_model = 7'h12;
            4'h6: seg_model = 7'h02;  4'h7: seg_model = 7'h78;
            4'h8: seg_model = 7'h00;  4'h9: seg_model = 7'h10;
            4'hA: seg_model = 7'h08;  4'hB: seg_model = 7'h03;
            4'hC: seg_model = 7'h46;  4'hD: seg_model = 7'h21;
            4'hE: seg_model = 7'h06;  default: seg_model = 7'h0E;
        endcase
    endfunction

    assign dec_seg = seg_model(dec_nibble);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        n_checks++; if (seg !== OFF) $display("FAIL reset_seg got=%h exp=%h", seg, OFF); else n_pass++;
        n_checks++; if (dig_sel !== 4'hF) $display("FAIL reset_sel got=%b exp=1111", dig_sel); else n_pass++;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_fd got=%b exp=0", frame_done); else n_pass++;
        n_checks++; if (dec_nibble !== 4'h0) $display("FAIL reset_nib got=%h exp=0", dec_nibble); else n_pass++;
    endtask

    task automatic test_write_digits;
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = 2'(i); wr_data = 4'(i + 1); wr_blank = 1'b0;
            tick;
            n_checks++; if (dig_sel !== 4'hF || seg !== OFF)
                $display("FAIL idle_write_%0d got sel=%b seg=%h exp sel=1111 seg=7f", i, dig_sel, seg);
            else n_pass++;
        end
        wr_en = 1'b0;
        n_checks++; if (dec_nibble !== 4'h1) $display("FAIL idle_nib got=%h exp=1", dec_nibble); else n_pass++;
    endtask

    // Edge e counted from the edge that sees enable=1: edge 1 leaves IDLE, and slot k is
    // dark after edges 8k+2, 8k+3 and shows digit k%4 after edges 8k+4 .. 8k+9.
    task automatic test_scan;
        logic [6:0] codes [4];
        logic [6:0] exp_seg;
        logic [3:0] exp_sel;
        logic       exp_fd;
        int k, ph;
        codes[0] = C_1; codes[1] = C_2; codes[2] = C_3; codes[3] = C_4;
        enable = 1'b1;
        for (int e = 1; e <= 66; e++) begin
            tick;
            exp_seg = OFF; exp_sel = 4'hF; exp_fd = (e == 33) || (e == 65);
            if (e >= 2) begin
                k = (e - 2) / 8; ph = (e - 2) % 8;
                if (ph >= 2) begin exp_sel = ~(4'b0001 << (k % 4)); exp_seg = codes[k % 4]; end
            end
            n_checks++; if (seg !== exp_seg) $display("FAIL scan_seg e=%0d got=%h exp=%h", e, seg, exp_seg); else n_pass++;
            n_checks++; if (dig_sel !== exp_sel) $display("FAIL scan_sel e=%0d got=%b exp=%b", e, dig_sel, exp_sel); else n_pass++;
            n_checks++; if (frame_done !== exp_fd) $display("FAIL scan_fd e=%0d got=%b exp=%b", e, frame_done, exp_fd); else n_pass++;
        end
    endtask

    task automatic test_blank;
        logic [6:0] codes [4];
        logic [6:0] exp_seg;
        logic [3:0] exp_sel;
        int k, ph;
        codes[0] = C_1; codes[1] = C_2; codes[2] = OFF; codes[3] = C_4;
        enable = 1'b0;
        tick;
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'h3; wr_blank = 1'b1;
        tick;
        wr_en = 1'b0;
        enable = 1'b1;
        for (int e = 1; e <= 33; e++) begin
            tick;
            exp_seg = OFF; exp_sel = 4'hF;
            if (e >= 2) begin
                k = (e - 2) / 8; ph = (e - 2) % 8;
                if (ph >= 2) begin exp_sel = ~(4'b0001 << k); exp_seg = codes[k]; end
            end
            n_checks++; if (seg !== exp_seg || dig_sel !== exp_sel)
                $display("FAIL blank_slot e=%0d got sel=%b seg=%h exp sel=%b seg=%h", e, dig_sel, seg, exp_sel, exp_seg);
            else n_pass++;
        end
    endtask

    // Covers a write into the showing digit, a write coinciding with slot advance,
    // dropping enable mid-slot and restarting.
    task automatic test_back_to_back;
        enable = 1'b0;
        tick;
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'h3; wr_blank = 1'b0;
        tick;
        wr_en = 1'b0;
        enable = 1'b1;
        for (int e = 1; e <= 5; e++) tick;
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'hA; wr_blank = 1'b0;
        tick;  // edge 6
        wr_en = 1'b0;
        n_checks++; if (seg !== C_1) $display("FAIL wr_show_e6 got=%h exp=%h", seg, C_1); else n_pass++;
        n_checks++; if (dec_nibble !== 4'hA) $display("FAIL wr_show_nib got=%h exp=a", dec_nibble); else n_pass++;
        tick;  // edge 7
        n_checks++; if (seg !== C_A || dig_sel !== 4'b1110)
            $display("FAIL wr_show_e7 got sel=%b seg=%h exp sel=1110 seg=%h", dig_sel, seg, C_A);
        else n_pass++;
        tick;  // edge 8
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'h5; wr_blank = 1'b0;
        tick;  // edge 9: write and slot advance together
        wr_en = 1'b0;
        n_checks++; if (dec_nibble !== 4'h5) $display("FAIL adv_nib got=%h exp=5", dec_nibble); else n_pass++;
        n_checks++; if (seg !== C_A || dig_sel !== 4'b1110)
            $display("FAIL adv_e9 got sel=%b seg=%h exp sel=1110 seg=%h", dig_sel, seg, C_A);
        else n_pass++;
        for (int e = 10; e <= 12; e++) tick;
        n_checks++; if (seg !== C_5 || dig_sel !== 4'b1101)
            $display("FAIL adv_e12 got sel=%b seg=%h exp sel=1101 seg=%h", dig_sel, seg, C_5);
        else n_pass++;
        for (int e = 13; e <= 30; e++) tick;
        n_checks++; if (seg !== C_4 || dig_sel !== 4'b0111)
            $display("FAIL dig3_e30 got sel=%b seg=%h exp sel=0111 seg=%h", dig_sel, seg, C_4);
        else n_pass++;
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick;
            n_checks++; if (seg !== OFF || dig_sel !== 4'hF || frame_done !== 1'b0)
                $display("FAIL disable_%0d got sel=%b seg=%h fd=%b exp sel=1111 seg=7f fd=0", i, dig_sel, seg, frame_done);
            else n_pass++;
        end
        n_checks++; if (dec_nibble !== 4'hA) $display("FAIL disable_nib got=%h exp=a", dec_nibble); else n_pass++;
        enable = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick;
            n_checks++;
            if (e < 4 && (seg !== OFF || dig_sel !== 4'hF))
                $display("FAIL reenable_e%0d got sel=%b seg=%h exp sel=1111 seg=7f", e, dig_sel, seg);
            else if (e == 4 && (seg !== C_A || dig_sel !== 4'b1110))
                $display("FAIL reenable_e4 got sel=%b seg=%h exp sel=1110 seg=%h", dig_sel, seg, C_A);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_show;
        tick;  // edge 5 after re-enable, digit 0 showing
        #3 reset = 1'b1;
        #1;
        n_checks++; if (seg !== OFF || dig_sel !== 4'hF || frame_done !== 1'b0)
            $display("FAIL async_rst got sel=%b seg=%h fd=%b exp sel=1111 seg=7f fd=0", dig_sel, seg, frame_done);
        else n_pass++;
        n_checks++; if (dec_nibble !== 4'h0) $display("FAIL async_rst_nib got=%h exp=0", dec_nibble); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick;
            if (e == 4 || e == 12) begin
                n_checks++; if (seg !== OFF || dig_sel !== ((e == 4) ? 4'b1110 : 4'b1101))
                    $display("FAIL rst_blanked_e%0d got sel=%b seg=%h exp seg=7f", e, dig_sel, seg);
                else n_pass++;
            end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0; wr_blank = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tick;
        test_reset;
        test_write_digits;
        test_scan;
        test_blank;
        test_back_to_back;
        test_reset_mid_show;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
